// File: rtl/masked_bv4_apply_theta_pkg.sv
// Shared bit-vector types and normal-basis GF(2^2)/GF(2^4) helpers for the masked inversion stages.
// GF(2^2) uses basis {W^2, W}; GF(2^4) uses basis {Z^4, Z} with Z^2 + Z + N = 0, N = W^2.
package masked_bv4_apply_theta_pkg;

    typedef logic [1:0] bv2_t;
    typedef logic [3:0] bv4_t;

    localparam bv2_t GF2_N   = 2'b10;
    localparam bv4_t GF4_ONE = 4'hF;

    // Number of unordered share pairs, i.e. randomness words per 2-bit HPC3 multiplier.
    function automatic int unsigned num_quad(input int unsigned shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    // Position of the unordered share pair {i, j} within a randomness field.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned shares);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    function automatic bv2_t gf2_mul(input bv2_t a, input bv2_t b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    function automatic bv4_t gf4_mul(input bv4_t a, input bv4_t b);
        bv2_t e;
        e = gf2_mul(gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), GF2_N);
        return {gf2_mul(a[3:2], b[3:2]) ^ e, gf2_mul(a[1:0], b[1:0]) ^ e};
    endfunction

    // Unmasked reference inverse (0 maps to 0); exhaustive search, intended for benches only.
    function automatic bv4_t bv4_inv_ref(input bv4_t x);
        bv4_t res;
        res = 4'h0;
        for (int k = 1; k < 16; k++) begin
            if (gf4_mul(x, 4'(k)) == GF4_ONE) begin
                res = 4'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hpc3_mul.sv
// HPC3 masked GF(2^2) multiplier, one register stage; randomness r/p is shared per unordered share pair.
module hpc3_mul
    import masked_bv4_apply_theta_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned BIT_WIDTH  = 2
) (
    input  logic                                               in_clock,
    input  logic                                               in_reset,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]               in_a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]               in_b,
    input  logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]     in_r,
    input  logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]     in_p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]               out_c
);

    // u holds a_i*b_i on the diagonal and a_i*(b_j^r_ij) elsewhere; v holds (a_i^1)*r_ij ^ p_ij.
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] u_q;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] v_q;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            u_q <= '0;
            v_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SHARES; i++) begin
                for (int unsigned j = 0; j < NUM_SHARES; j++) begin
                    if (i == j) begin
                        u_q[i][j] <= gf2_mul(in_a[i], in_b[i]);
                        v_q[i][j] <= '0;
                    end else begin
                        u_q[i][j] <= gf2_mul(in_a[i], in_b[j] ^ in_r[pair_idx(i, j, NUM_SHARES)]);
                        v_q[i][j] <= gf2_mul(~in_a[i], in_r[pair_idx(i, j, NUM_SHARES)])
                                     ^ in_p[pair_idx(i, j, NUM_SHARES)];
                    end
                end
            end
        end
    end

    // Output share i only folds registered terms belonging to share i.
    always_comb begin
        logic [BIT_WIDTH-1:0] acc;
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            acc = '0;
            for (int unsigned j = 0; j < NUM_SHARES; j++) begin
                acc = acc ^ u_q[i][j] ^ v_q[i][j];
            end
            out_c[i] = acc;
        end
    end

endmodule

// File: rtl/valid_shift.sv
// Parametrised-depth valid pipeline with asynchronous active-low reset.
module valid_shift #(
    parameter int unsigned DEPTH = 2
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] stage_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge in_clock or negedge in_reset) begin
                if (!in_reset) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= in_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge in_clock or negedge in_reset) begin
                if (!in_reset) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= {stage_q[DEPTH-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign out_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/masked_bv4_apply_theta.sv
// Final stage of the masked GF(2^4) inversion: inverse = {Theta*Gamma_lo, Theta*Gamma_hi}.
// Optional MASKED_BV4_APPLY_THETA_OUT_GATE_EN forces out_b to zero whenever out_valid is low.
module masked_bv4_apply_theta
    import masked_bv4_apply_theta_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic                                  in_valid,
    input  bv4_t [NUM_SHARES-1:0]                 in_gamma,
    input  bv2_t [NUM_SHARES-1:0]                 in_theta,
    input  logic [8*num_quad(NUM_SHARES)-1:0]     in_random,
    output bv4_t [NUM_SHARES-1:0]                 out_b,
    output logic                                  out_valid
);

    localparam int unsigned NUM_QUAD = num_quad(NUM_SHARES);

    bv4_t [NUM_SHARES-1:0] gamma_q;
    bv2_t [NUM_SHARES-1:0] g_hi;
    bv2_t [NUM_SHARES-1:0] g_lo;
    bv2_t [NUM_SHARES-1:0] c_hi;
    bv2_t [NUM_SHARES-1:0] c_lo;
    bv2_t [NUM_QUAD-1:0]   r_hi;
    bv2_t [NUM_QUAD-1:0]   p_hi;
    bv2_t [NUM_QUAD-1:0]   r_lo;
    bv2_t [NUM_QUAD-1:0]   p_lo;

    assign {r_hi, p_hi, r_lo, p_lo} = in_random;

    // Gamma delay so it meets Theta, which arrives one cycle later.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= in_gamma;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            g_hi[i] = gamma_q[i][3:2];
            g_lo[i] = gamma_q[i][1:0];
        end
    end

    hpc3_mul #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (2)
    ) mul_hi (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_theta),
        .in_b     (g_lo),
        .in_r     (r_hi),
        .in_p     (p_hi),
        .out_c    (c_hi)
    );

    hpc3_mul #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (2)
    ) mul_lo (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_theta),
        .in_b     (g_hi),
        .in_r     (r_lo),
        .in_p     (p_lo),
        .out_c    (c_lo)
    );

    valid_shift #(
        .DEPTH (2)
    ) u_valid (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_valid  (in_valid),
        .out_valid (out_valid)
    );

`ifdef MASKED_BV4_APPLY_THETA_OUT_GATE_EN
    logic gate;

    // Separate register copy of out_valid so the gate is flop-driven.
    valid_shift #(
        .DEPTH (2)
    ) u_gate (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_valid  (in_valid),
        .out_valid (gate)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            out_b[i] = {c_hi[i], c_lo[i]} & {4{gate}};
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            out_b[i] = {c_hi[i], c_lo[i]};
        end
    end
`endif

endmodule

// File: tb/tb_masked_bv4_apply_theta.sv
// Randomised self-checking bench for masked_bv4_apply_theta against an unmasked field model.
module tb_masked_bv4_apply_theta;
    import masked_bv4_apply_theta_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned RW = 8 * num_quad(NS);

    typedef bv4_t [NS-1:0] sh4_t;
    typedef bv2_t [NS-1:0] sh2_t;

    logic           in_clock = 1'b0;
    logic           in_reset;
    logic           in_valid;
    sh4_t           in_gamma;
    sh2_t           in_theta;
    logic [RW-1:0]  in_random;
    sh4_t           out_b;
    logic           out_valid;

    int checks = 0;
    int failures = 0;

    logic        prev_v;
    bv4_t        prev_exp;
    bv2_t        pend_theta;
    int unsigned valid_run;
    int unsigned max_run;
    logic        track_share;
    logic        share0_seen;
    logic        share0_varied;
    bv4_t        share0_first;

    masked_bv4_apply_theta #(
        .NUM_SHARES (NS)
    ) dut (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_valid  (in_valid),
        .in_gamma  (in_gamma),
        .in_theta  (in_theta),
        .in_random (in_random),
        .out_b     (out_b),
        .out_valid (out_valid)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // GF(2^2) product from the basis table: W2*W2=W, W*W=W2, W2*W=1=W2+W.
    function automatic bv2_t m_mul2(input bv2_t a, input bv2_t b);
        bv2_t r;
        r = 2'b00;
        if (a[1] && b[1]) r = r ^ 2'b01;
        if (a[0] && b[0]) r = r ^ 2'b10;
        if ((a[1] && b[0]) != (a[0] && b[1])) r = r ^ 2'b11;
        return r;
    endfunction

    function automatic bv2_t m_inv2(input bv2_t x);
        bv2_t r;
        r = 2'b00;
        for (int k = 1; k < 4; k++) begin
            if (m_mul2(x, 2'(k)) == 2'b11) r = 2'(k);
        end
        return r;
    endfunction

    // GF(2^4) product from basis products: Zb*Zb=(W,N), Z*Z=(N,W), Zb*Z=(N,N).
    function automatic bv4_t m_mul4(input bv4_t a, input bv4_t b);
        bv2_t thh, tll, tx, hi, lo;
        thh = m_mul2(a[3:2], b[3:2]);
        tll = m_mul2(a[1:0], b[1:0]);
        tx  = m_mul2(a[3:2], b[1:0]) ^ m_mul2(a[1:0], b[3:2]);
        hi  = m_mul2(thh, 2'b01) ^ m_mul2(tll, 2'b10) ^ m_mul2(tx, 2'b10);
        lo  = m_mul2(thh, 2'b10) ^ m_mul2(tll, 2'b01) ^ m_mul2(tx, 2'b10);
        return {hi, lo};
    endfunction

    function automatic bv4_t m_inv4(input bv4_t x);
        bv4_t r;
        r = 4'h0;
        for (int k = 1; k < 16; k++) begin
            if (m_mul4(x, 4'(k)) == 4'hF) r = 4'(k);
        end
        return r;
    endfunction

    // Upstream stage: Theta = (g_hi*g_lo + N*(g_hi+g_lo)^2)^-1.
    function automatic bv2_t m_theta(input bv4_t g);
        bv2_t s;
        s = g[3:2] ^ g[1:0];
        return m_inv2(m_mul2(g[3:2], g[1:0]) ^ m_mul2(2'b10, m_mul2(s, s)));
    endfunction

    function automatic sh4_t share4(input bv4_t v);
        sh4_t s;
        bv4_t acc;
        acc = v;
        for (int i = 0; i < NS - 1; i++) begin
            s[i] = 4'($urandom());
            acc = acc ^ s[i];
        end
        s[NS-1] = acc;
        return s;
    endfunction

    function automatic sh2_t share2(input bv2_t v);
        sh2_t s;
        bv2_t acc;
        acc = v;
        for (int i = 0; i < NS - 1; i++) begin
            s[i] = 2'($urandom());
            acc = acc ^ s[i];
        end
        s[NS-1] = acc;
        return s;
    endfunction

    function automatic bv4_t unmask4(input sh4_t s);
        bv4_t acc;
        acc = 4'h0;
        for (int i = 0; i < NS; i++) acc = acc ^ s[i];
        return acc;
    endfunction

    // One clock: drive Gamma for this item and Theta for the previous one, then check the item before.
    task automatic step(input logic v, input bv4_t g);
        bv4_t got;
        in_valid  = v;
        in_gamma  = share4(g);
        in_theta  = share2(pend_theta);
        in_random = RW'($urandom());
        @(negedge in_clock);
        got = unmask4(out_b);
        check("out_valid", 32'(out_valid), 32'(prev_v));
`ifdef MASKED_BV4_APPLY_THETA_OUT_GATE_EN
        if (prev_v) check("out_b", 32'(got), 32'(prev_exp));
        else        check("out_b_gated", 32'(out_b), 32'd0);
`else
        check("out_b", 32'(got), 32'(prev_exp));
`endif
        if (out_valid) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
        end else begin
            valid_run = 0;
        end
        if (track_share) begin
            if (!share0_seen) begin
                share0_first = out_b[0];
                share0_seen  = 1'b1;
            end else if (out_b[0] != share0_first) begin
                share0_varied = 1'b1;
            end
        end
        prev_v     = v;
        prev_exp   = m_inv4(g);
        pend_theta = m_theta(g);
    endtask

    // Entered and left at a falling edge; reset is released there so the next rising edge accepts data.
    task automatic do_reset(input int unsigned hold);
        in_reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_b", 32'(out_b), 32'd0);
        for (int unsigned k = 0; k < hold; k++) begin
            @(negedge in_clock);
            check("rst_valid_hold", 32'(out_valid), 32'd0);
            check("rst_b_hold", 32'(out_b), 32'd0);
        end
        in_reset   = 1'b1;
        prev_v     = 1'b0;
        prev_exp   = 4'h0;
        pend_theta = 2'b00;
    endtask

    initial begin
        in_reset      = 1'b0;
        in_valid      = 1'b0;
        in_gamma      = '0;
        in_theta      = '0;
        in_random     = '0;
        prev_v        = 1'b0;
        prev_exp      = 4'h0;
        pend_theta    = 2'b00;
        valid_run     = 0;
        max_run       = 0;
        track_share   = 1'b0;
        share0_seen   = 1'b0;
        share0_varied = 1'b0;
        share0_first  = 4'h0;

        @(negedge in_clock);
        do_reset(3);

        for (int x = 0; x < 16; x++) begin
            check("inv_ref_pkg", 32'(bv4_inv_ref(4'(x))), 32'(m_inv4(4'(x))));
        end

        // Zero vector after a few idle cycles carrying non-zero data.
        repeat (4) step(1'b0, 4'($urandom_range(1, 15)));
        step(1'b1, 4'h0);
        repeat (2) step(1'b0, 4'($urandom_range(1, 15)));

        // Streaming all 16 values back to back.
        valid_run = 0;
        max_run   = 0;
        for (int x = 0; x < 16; x++) step(1'b1, 4'(x));
        repeat (3) step(1'b0, 4'($urandom()));
        check("stream_run", 32'(max_run), 32'd16);

        // Same Gamma with fresh sharing and randomness each cycle.
        track_share = 1'b1;
        repeat (50) step(1'b1, 4'h9);
        track_share = 1'b0;
        check("share_vary", 32'(share0_varied), 32'd1);

        repeat (200) step(1'($urandom_range(0, 1)), 4'($urandom()));

        // Reset while an item is in flight; it must never appear.
        step(1'b1, 4'($urandom_range(1, 15)));
        do_reset(1);
        repeat (3) step(1'b0, 4'($urandom()));

        // First edge after release accepts data.
        step(1'b1, 4'h5);
        step(1'b1, 4'hA);
        repeat (2) step(1'b0, 4'($urandom()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
